// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end: frame FSM states and the
// scan codes the arrow decoder recognises.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int TO_CNT_W = 12;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 deframer: pin synchronisers, optional ps2_clk glitch filter (PS2_GLITCH_FILTER_EN),
// 11-bit frame FSM with parity/stop checks and an inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500
`ifdef PS2_GLITCH_FILTER_EN
  ,
  parameter int FILTER_LEN = 4
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_scan_code,
  output logic       o_scan_valid,
  output logic       o_frame_err
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]          r_clk_sync;
  logic [1:0]          r_data_sync;
  logic                r_clk_prev;
  logic                w_clk_filt;
  logic                w_fall;
  logic                w_data;
  logic                w_timeout;

  ps2_state_t          r_state, w_state_nxt;
  logic [2:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic                r_par, w_par_nxt;
  logic                r_par_ok, w_par_ok_nxt;
  logic [7:0]          r_shreg, w_shreg_nxt;
  logic [7:0]          r_scan_code, w_scan_code_nxt;
  logic                r_scan_valid, w_scan_valid_nxt;
  logic                r_frame_err, w_frame_err_nxt;
  logic [TO_CNT_W-1:0] r_to_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  logic [FLT_W-1:0] r_flt_cnt;
  logic             r_clk_filt;

  // Output follows the synchronised clock only after FILTER_LEN differing samples in a row.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flt_cnt  <= '0;
      r_clk_filt <= 1'b1;
    end else if (r_clk_sync[1] == r_clk_filt) begin
      r_flt_cnt  <= '0;
    end else if (r_flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
      r_flt_cnt  <= '0;
      r_clk_filt <= r_clk_sync[1];
    end else begin
      r_flt_cnt  <= r_flt_cnt + FLT_W'(1);
    end
  end

  assign w_clk_filt = r_clk_filt;
`else
  assign w_clk_filt = r_clk_sync[1];
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_prev <= w_clk_filt;
    end
  end

  assign w_fall    = r_clk_prev & ~w_clk_filt;
  assign w_data    = r_data_sync[1];
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_to_cnt == TO_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (r_state == IDLE || w_fall) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_LAST) begin
      r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_par        <= 1'b0;
      r_par_ok     <= 1'b0;
      r_shreg      <= '0;
      r_scan_code  <= '0;
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_par        <= w_par_nxt;
      r_par_ok     <= w_par_ok_nxt;
      r_shreg      <= w_shreg_nxt;
      r_scan_code  <= w_scan_code_nxt;
      r_scan_valid <= w_scan_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  // A falling edge takes priority over the timeout, so a late-but-valid edge is never lost.
  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_par_nxt        = r_par;
    w_par_ok_nxt     = r_par_ok;
    w_shreg_nxt      = r_shreg;
    w_scan_code_nxt  = r_scan_code;
    w_scan_valid_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_fall && !w_data) begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = '0;
          w_par_nxt     = 1'b0;
        end
      end
      DATA: begin
        if (w_fall) begin
          w_shreg_nxt   = {w_data, r_shreg[7:1]};
          w_par_nxt     = r_par ^ w_data;
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = PARITY;
          end
        end
      end
      PARITY: begin
        if (w_fall) begin
          w_par_ok_nxt = r_par ^ w_data;
          w_state_nxt  = STOP;
        end
      end
      STOP: begin
        if (w_fall) begin
          if (w_data && r_par_ok) begin
            w_scan_code_nxt  = r_shreg;
            w_scan_valid_nxt = 1'b1;
          end else begin
            w_frame_err_nxt  = 1'b1;
          end
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_timeout) begin
      w_state_nxt     = IDLE;
      w_frame_err_nxt = 1'b1;
    end
  end

  assign o_scan_code  = r_scan_code;
  assign o_scan_valid = r_scan_valid;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard front end: deframer plus E0/F0 decoder producing arrow-key held levels.
// PS2_GLITCH_FILTER_EN enables the ps2_clk glitch filter inside the deframer.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500
`ifdef PS2_GLITCH_FILTER_EN
  ,
  parameter int FILTER_LEN = 4
`endif
) (
  input  logic       i_vga_clk,
  input  logic       i_reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_scan_code,
  output logic       o_scan_valid,
  output logic       o_frame_err,
  output logic       o_key_up,
  output logic       o_key_down,
  output logic       o_key_left,
  output logic       o_key_right,
  output logic       o_key_event
);

  logic [7:0] w_scan_code;
  logic       w_scan_valid;
  logic       w_frame_err;

  logic       r_ext, w_ext_nxt;
  logic       r_brk, w_brk_nxt;
  logic [3:0] r_keys, w_keys_nxt;
  logic [3:0] w_sel;
  logic       r_key_event;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`ifdef PS2_GLITCH_FILTER_EN
    ,
    .FILTER_LEN(FILTER_LEN)
`endif
  ) u_frame_rx (
    .i_clk       (i_vga_clk),
    .i_rst       (i_reset),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .o_scan_code (w_scan_code),
    .o_scan_valid(w_scan_valid),
    .o_frame_err (w_frame_err)
  );

  // r_keys is packed {up, down, left, right}; only E0-prefixed arrow codes touch it.
  always_comb begin
    w_ext_nxt  = r_ext;
    w_brk_nxt  = r_brk;
    w_keys_nxt = r_keys;
    w_sel      = 4'b0000;

    if (w_frame_err) begin
      w_ext_nxt = 1'b0;
      w_brk_nxt = 1'b0;
    end else if (w_scan_valid) begin
      if (w_scan_code == SC_EXT) begin
        w_ext_nxt = 1'b1;
      end else if (w_scan_code == SC_BRK) begin
        w_brk_nxt = 1'b1;
      end else begin
        if (r_ext) begin
          case (w_scan_code)
            SC_UP:    w_sel = 4'b1000;
            SC_DOWN:  w_sel = 4'b0100;
            SC_LEFT:  w_sel = 4'b0010;
            SC_RIGHT: w_sel = 4'b0001;
            default:  w_sel = 4'b0000;
          endcase
        end
        w_ext_nxt = 1'b0;
        w_brk_nxt = 1'b0;
      end
    end

    for (int i = 0; i < 4; i++) begin
      if (w_sel[i]) begin
        w_keys_nxt[i] = ~r_brk;
      end
    end
  end

  always_ff @(posedge i_vga_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_keys      <= 4'b0000;
      r_key_event <= 1'b0;
    end else begin
      r_ext       <= w_ext_nxt;
      r_brk       <= w_brk_nxt;
      r_keys      <= w_keys_nxt;
      r_key_event <= (w_keys_nxt != r_keys);
    end
  end

  assign o_scan_code  = w_scan_code;
  assign o_scan_valid = w_scan_valid;
  assign o_frame_err  = w_frame_err;
  assign o_key_up     = r_keys[3];
  assign o_key_down   = r_keys[2];
  assign o_key_left   = r_keys[1];
  assign o_key_right  = r_keys[0];
  assign o_key_event  = r_key_event;

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- PS/2 keyboard front end that sits directly upstream of the VGA square-mover logic.
- Synchronises `ps2_clk`/`ps2_data`, deframes 11-bit PS/2 frames with parity, stop and timeout checking, and emits one-cycle scan-code strobes.
- Decodes E0/F0 sequences into clean per-arrow pressed/released levels that the display stage consumes directly.
- Replaces ad-hoc shift-register capture, which has no parity check, no resync and no release handling.

Parameters:
- `TIMEOUT_CYCLES`, 2500, `vga_clk` cycles without a `ps2_clk` falling edge before a partial frame is aborted (100 us at 25 MHz).
- `FILTER_LEN`, 4, consecutive identical samples required by the glitch filter (used only with the optional feature).

Ports:
- `vga_clk`  in  1  25 MHz system clock
- `reset`  in  1  asynchronous, active-high reset
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous
- `scan_code`  out  8  last accepted byte; holds until the next accepted byte
- `scan_valid`  out  1  one-cycle strobe, `scan_code` is new
- `frame_err`  out  1  one-cycle strobe on parity, stop or timeout error
- `key_up`, `key_down`, `key_left`, `key_right`  out  1 each  arrow held levels
- `key_event`  out  1  one-cycle strobe when any arrow level changes

Behaviour:
- Reset: asynchronous, active-high, as decided.
  - All outputs 0; FSM in IDLE; synchroniser flops 1; `ext` and `brk` flags 0; counters 0.
  - Reset asserted mid-frame discards the frame; no strobe is emitted.
- Input path:
  - 2-flop synchroniser per pin.
  - Falling edge of `ps2_clk` = sync'd value registered as 1, now 0.
  - Data is sampled on that same cycle.
- Frame FSM (`bit_cnt` is 3 bits, `par` is 1 bit):
  - IDLE: on a falling edge with data=0 → DATA, `bit_cnt`=0, `par`=0. A falling edge with data=1 is ignored.
  - DATA: each edge shifts data into `shreg` LSB-first and does `par ^= data`. Leave on `bit_cnt`==7 → PARITY.
  - PARITY: on edge, `par_ok = par ^ data` (odd parity requires 1) → STOP.
  - STOP: on edge, if data==1 and `par_ok`, then `scan_code` <= `shreg` and `scan_valid`=1 for the next cycle. Otherwise `frame_err`=1. Always → IDLE.
- Timeout:
  - 12-bit counter cleared on every falling edge and in IDLE; it increments in any other state.
  - On reaching `TIMEOUT_CYCLES-1`: `frame_err`=1 and → IDLE. The counter saturates and does not wrap.
- Latency: `scan_valid` is high exactly 1 cycle after the cycle the stop-bit falling edge is detected, i.e. 3 `vga_clk` cycles after the raw pin edge.
- Decoder (acts on `scan_valid`; outputs register 1 cycle later):
  - Byte E0: `ext`=1.
  - Byte F0: `brk`=1.
  - Any other byte with `ext`=1: on 75 (up), 72 (down), 6B (left) or 74 (right), the matching level <= ~`brk`. `key_event`=1 if the level changed.
  - Any other byte: `ext` and `brk` cleared.
  - Non-extended bytes (e.g. keypad 75 without E0) leave the arrow levels unchanged.
- `frame_err` clears `ext` and `brk`, so a corrupted sequence cannot latch a key.
- Opposing arrows (up+down) may both be held; arbitration belongs to the consumer.
- Strobes never overlap: `scan_valid` and `frame_err` are mutually exclusive.

Optional Feature:
- Macro: `PS2_GLITCH_FILTER_EN`.
- Defined: after the synchroniser, `ps2_clk` passes through a filter that changes output only after `FILTER_LEN` identical consecutive samples. This adds `FILTER_LEN` cycles of latency; edge detection uses the filtered signal.
- Undefined: edge detection uses the synchroniser output directly, and `FILTER_LEN` is unused.

Decomposition:
- Shared package `ps2_pkg`:
  - FSM state enum (IDLE/DATA/PARITY/STOP).
  - Scan-code constants: `SC_EXT`=8'hE0, `SC_BRK`=8'hF0, `SC_UP`=8'h75, `SC_DOWN`=8'h72, `SC_LEFT`=8'h6B, `SC_RIGHT`=8'h74.
- One sub-module, `ps2_frame_rx`: synchroniser, optional filter, FSM and timeout.
- The top level instantiates it and holds the E0/F0 decoder.

Test Plan:
- Send E0 (parity 0), then 75 (parity 0), at 12.5 kHz → two `scan_valid` strobes with codes E0, 75. `key_up`=1 and one `key_event`.
- Send E0, F0 (parity 1), 75 → `key_up` returns to 0 with one `key_event`; `scan_code` ends at 75.
- Send 6B with parity bit 1 (wrong) → `frame_err` pulse, no `scan_valid`, `scan_code` unchanged, `key_left` stays 0.
- Send start bit + 4 data bits, then idle 2600 cycles → `frame_err` pulse at cycle 2500. A following complete frame 1C is received correctly.
- Send 75 without E0 → `scan_valid` with 75; all arrow levels stay 0, no `key_event`.
- Assert `reset` mid-frame after bit 5 → outputs 0 immediately. After release, a full E0,74 sequence sets `key_right`=1.
- With `PS2_GLITCH_FILTER_EN` defined, inject a 2-cycle low glitch on idle `ps2_clk` → no FSM activity and no strobes.
